// File: rtl/aes_ahb_pkg.sv
// Shared types and register map for the AES slave burst master.
// Bus encodings, job states and the beat record carried from address to data phase.
package aes_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1
    } hburst_t;

    localparam logic [2:0]  HSIZE_WORD = 3'd2;
    localparam logic [1:0]  HRESP_OKAY  = 2'd0;
    localparam logic [1:0]  HRESP_ERROR = 2'd1;

    localparam logic [31:0] MODE_ENC   = 32'h0000_0004;
    localparam logic [31:0] MODE_DEC   = 32'h0000_0008;
    localparam logic [31:0] KEY_BASE   = 32'h0000_0010;
    localparam logic [31:0] WDATA_BASE = 32'h0000_0040;
    localparam logic [31:0] RDATA_BASE = 32'h0000_0080;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MODE  = 3'd1,
        ST_KEY   = 3'd2,
        ST_WDATA = 3'd3,
        ST_RDATA = 3'd4,
        ST_TAIL  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       write;
        state_t     phase;
        logic [3:0] idx;
    } beat_t;

    // Word idx of a 512-bit vector, word 0 being the most significant.
    function automatic logic [31:0] pick_word(input logic [511:0] v, input logic [3:0] idx);
        return v[511 - 32*idx -: 32];
    endfunction

endpackage

// File: rtl/ahb_pipe_reg.sv
// Carries the accepted address-phase beat into its data phase.
// Advances only when HREADY completes the current transfer.
module ahb_pipe_reg
    import aes_ahb_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_ready,
    input  beat_t i_beat,
    output beat_t o_beat
);

    beat_t r_beat;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_beat <= '0;
        end else if (i_ready) begin
            r_beat <= i_beat;
        end
    end

    assign o_beat = r_beat;

endmodule

// File: rtl/aes_ahb_master.sv
// AHB-Lite master sequencing one AES job: mode, key, four blocks in, four blocks out.
// Single FSM with registered bus outputs; data-phase selection comes from ahb_pipe_reg.
module aes_ahb_master
    import aes_ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         HCLK,
    input  logic         HRESET,
    input  logic         start,
    input  logic         decrypt,
    input  logic [127:0] key,
    input  logic [511:0] din,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [511:0] dout,
    output logic         HSELx,
    output logic [31:0]  HADDR,
    output logic [1:0]   HTRANS,
    output logic         HWRITE,
    output logic [2:0]   HBURST,
    output logic [2:0]   HSIZE,
    output logic [3:0]   HPROT,
    output logic [31:0]  HWDATA,
    input  logic [31:0]  HRDATA,
    input  logic         HREADY,
    input  logic [1:0]   HRESP
);

    state_t       r_state;
    logic [3:0]   r_beat;
    logic [127:0] r_key;
    logic [511:0] r_din;
    logic [511:0] r_dout;
    logic         r_busy, r_done, r_error;
    logic         r_hsel, r_hwrite;
    logic [31:0]  r_haddr;
    htrans_t      r_htrans;
    hburst_t      r_hburst;

    logic [3:0]   w_beat_inc;
    logic [31:0]  w_step_off;
    beat_t        w_abeat, w_dbeat;
    logic [31:0]  w_hwdata;
    logic         w_data_err, w_rd_capture;

    assign w_beat_inc   = r_beat + 4'd1;
    assign w_step_off   = {26'd0, w_beat_inc, 2'b00};
    assign w_data_err   = w_dbeat.valid && !HREADY && (HRESP == HRESP_ERROR);
    assign w_rd_capture = w_dbeat.valid && !w_dbeat.write && HREADY && (HRESP == HRESP_OKAY);

    always_comb begin
        w_abeat       = '0;
        w_abeat.valid = (r_htrans != HTRANS_IDLE);
        w_abeat.write = r_hwrite;
        w_abeat.phase = r_state;
        w_abeat.idx   = r_beat;
    end

    ahb_pipe_reg u_pipe (
        .i_clk   (HCLK),
        .i_rst   (HRESET),
        .i_ready (HREADY),
        .i_beat  (w_abeat),
        .o_beat  (w_dbeat)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_hwdata = '0;
        if (w_dbeat.valid && w_dbeat.write) begin
            case (w_dbeat.phase)
                ST_KEY:   w_hwdata = pick_word({r_key, 384'd0}, w_dbeat.idx);
                ST_WDATA: w_hwdata = pick_word(r_din, w_dbeat.idx);
                default:  w_hwdata = '0;
            endcase
        end
    end

    // NOTE: job operands carry no reset; they are only consumed while a beat is in flight.
    always_ff @(posedge HCLK) begin
        if (r_state == ST_IDLE && start) begin
            r_key <= key;
            r_din <= din;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= ST_IDLE;
            r_beat   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_hsel   <= 1'b0;
            r_hwrite <= 1'b0;
            r_haddr  <= '0;
            r_htrans <= HTRANS_IDLE;
            r_hburst <= HBURST_SINGLE;
            r_dout   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_rd_capture) begin
                r_dout[511 - 32*w_dbeat.idx -: 32] <= HRDATA;
            end
            if (w_data_err) begin
                // First ERROR cycle: drop the pending address phase and drain through TAIL.
                r_state  <= ST_TAIL;
                r_error  <= 1'b1;
                r_hsel   <= 1'b0;
                r_hwrite <= 1'b0;
                r_haddr  <= '0;
                r_htrans <= HTRANS_IDLE;
                r_hburst <= HBURST_SINGLE;
            end else begin
                case (r_state)
                    ST_IDLE: if (start) begin
                        r_state  <= ST_MODE;
                        r_beat   <= '0;
                        r_busy   <= 1'b1;
                        r_error  <= 1'b0;
                        r_hsel   <= 1'b1;
                        r_hwrite <= 1'b1;
                        r_htrans <= HTRANS_NONSEQ;
                        r_hburst <= HBURST_SINGLE;
                        r_haddr  <= BASE_ADDR + (decrypt ? MODE_DEC : MODE_ENC);
                    end
                    ST_MODE: if (HREADY) begin
                        r_state  <= ST_KEY;
                        r_beat   <= '0;
                        r_htrans <= HTRANS_NONSEQ;
                        r_hburst <= HBURST_INCR;
                        r_haddr  <= BASE_ADDR + KEY_BASE;
                    end
                    ST_KEY: if (HREADY) begin
                        if (r_beat == 4'd3) begin
                            r_state  <= ST_WDATA;
                            r_beat   <= '0;
                            r_htrans <= HTRANS_NONSEQ;
                            r_haddr  <= BASE_ADDR + WDATA_BASE;
                        end else begin
                            r_beat   <= w_beat_inc;
                            r_htrans <= HTRANS_SEQ;
                            r_haddr  <= BASE_ADDR + KEY_BASE + w_step_off;
                        end
                    end
                    ST_WDATA: if (HREADY) begin
                        if (r_beat == 4'd15) begin
                            r_state  <= ST_RDATA;
                            r_beat   <= '0;
                            r_hwrite <= 1'b0;
                            r_htrans <= HTRANS_NONSEQ;
                            r_haddr  <= BASE_ADDR + RDATA_BASE;
                        end else begin
                            r_beat   <= w_beat_inc;
                            r_htrans <= HTRANS_SEQ;
                            r_haddr  <= BASE_ADDR + WDATA_BASE + w_step_off;
                        end
                    end
                    ST_RDATA: if (HREADY) begin
                        if (r_beat == 4'd15) begin
                            r_state  <= ST_TAIL;
                            r_beat   <= '0;
                            r_hsel   <= 1'b0;
                            r_htrans <= HTRANS_IDLE;
                            r_hburst <= HBURST_SINGLE;
                            r_haddr  <= '0;
                        end else begin
                            r_beat   <= w_beat_inc;
                            r_htrans <= HTRANS_SEQ;
                            r_haddr  <= BASE_ADDR + RDATA_BASE + w_step_off;
                        end
                    end
                    ST_TAIL: if (HREADY) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign error  = r_error;
    assign dout   = r_dout;
    assign HSELx  = r_hsel;
    assign HADDR  = r_haddr;
    assign HTRANS = r_htrans;
    assign HWRITE = r_hwrite;
    assign HBURST = r_hburst;
    assign HSIZE  = HSIZE_WORD;
    assign HPROT  = 4'd0;
    assign HWDATA = w_hwdata;

endmodule

// File: tb/tb_aes_ahb_master.sv
// Bench for aes_ahb_master: reactive slave model at the falling edge plus a beat scoreboard.
// Expected beats are queued when a job starts and popped as address phases complete.
module tb_aes_ahb_master;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } beat_exp_t;

    logic         HCLK = 1'b0;
    logic         HRESET, start, decrypt;
    logic [127:0] key;
    logic [511:0] din;
    logic         busy, done, error;
    logic [511:0] dout;
    logic         HSELx, HWRITE;
    logic [31:0]  HADDR, HWDATA, HRDATA;
    logic [1:0]   HTRANS, HRESP;
    logic [2:0]   HBURST, HSIZE;
    logic [3:0]   HPROT;
    logic         HREADY;

    int checks = 0;
    int errors = 0;

    beat_exp_t   sb[$];
    logic        dp_valid = 1'b0, dp_write = 1'b0;
    logic [31:0] dp_addr = '0, dp_wdata = '0;
    int          ws = 0;
    logic        hold_valid = 1'b0, hold_write = 1'b0;
    logic [31:0] hold_addr = '0, hold_wdata = '0;
    logic [1:0]  hold_trans = '0;
    logic [2:0]  hold_burst = '0;
    logic        err_pending = 1'b0;
    int          rd_count = 0;
    logic [31:0] wait_addr = 32'hFFFF_FFFF;
    int          wait_n = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    aes_ahb_master #(.BASE_ADDR(32'h0000_0000)) dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .start   (start),
        .decrypt (decrypt),
        .key     (key),
        .din     (din),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .dout    (dout),
        .HSELx   (HSELx),
        .HADDR   (HADDR),
        .HTRANS  (HTRANS),
        .HWRITE  (HWRITE),
        .HBURST  (HBURST),
        .HSIZE   (HSIZE),
        .HPROT   (HPROT),
        .HWDATA  (HWDATA),
        .HRDATA  (HRDATA),
        .HREADY  (HREADY),
        .HRESP   (HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    function automatic logic [511:0] exp_dout();
        logic [511:0] e;
        e = '0;
        for (int k = 0; k < 16; k++) e[511 - 32*k -: 32] = model_rd(32'h80 + 4*k);
        return e;
    endfunction

    task automatic push_job(input logic dec, input logic [127:0] k, input logic [511:0] d);
        sb.push_back('{dec ? 32'h08 : 32'h04, 1'b1, 2'd2, 3'd0, 32'h0});
        for (int j = 0; j < 4; j++)
            sb.push_back('{32'h10 + 4*j, 1'b1, (j == 0) ? 2'd2 : 2'd3, 3'd1, k[127 - 32*j -: 32]});
        for (int j = 0; j < 16; j++)
            sb.push_back('{32'h40 + 4*j, 1'b1, (j == 0) ? 2'd2 : 2'd3, 3'd1, d[511 - 32*j -: 32]});
        for (int j = 0; j < 16; j++)
            sb.push_back('{32'h80 + 4*j, 1'b0, (j == 0) ? 2'd2 : 2'd3, 3'd1, 32'h0});
    endtask

    // One slave cycle: answer the data phase, then check and accept the address phase.
    task automatic slave_step();
        beat_exp_t e;
        if (HRESET) begin
            dp_valid = 1'b0; ws = 0; hold_valid = 1'b0; err_pending = 1'b0;
            HREADY = 1'b1; HRESP = 2'd0; HRDATA = 32'h0;
            return;
        end
        if (err_pending) begin
            check("err_next_htrans", HTRANS, 2'd0);
            check("err_next_hsel", HSELx, 1'b0);
            err_pending = 1'b0;
        end
        HREADY = 1'b1; HRESP = 2'd0; HRDATA = 32'hBAD0_BAD0;
        if (dp_valid) begin
            if (dp_addr == err_addr) begin
                HRESP  = 2'd1;
                HREADY = (ws >= 1);
                if (ws == 0) err_pending = 1'b1;
            end else if (dp_addr == wait_addr) begin
                HREADY = (ws >= wait_n);
            end
            if (!dp_write && HREADY) HRDATA = model_rd(dp_addr);
            if (dp_write && HREADY) check("hwdata", HWDATA, dp_wdata);
        end
        if (HTRANS != 2'd0) begin
            check("hsel_active", HSELx, 1'b1);
            if (hold_valid) begin
                check("hold_haddr", HADDR, hold_addr);
                check("hold_htrans", HTRANS, hold_trans);
                check("hold_hwrite", HWRITE, hold_write);
                check("hold_hburst", HBURST, hold_burst);
                check("hold_hwdata", HWDATA, hold_wdata);
            end
            hold_valid = !HREADY;
            hold_addr = HADDR; hold_trans = HTRANS; hold_write = HWRITE;
            hold_burst = HBURST; hold_wdata = HWDATA;
            if (HREADY) begin
                if (sb.size() == 0) begin
                    check("extra_beat_htrans", HTRANS, 2'd0);
                    dp_valid = 1'b0;
                end else begin
                    e = sb.pop_front();
                    check("haddr", HADDR, e.addr);
                    check("htrans", HTRANS, e.trans);
                    check("hwrite", HWRITE, e.write);
                    check("hburst", HBURST, e.burst);
                    dp_valid = 1'b1; dp_addr = e.addr; dp_write = e.write; dp_wdata = e.wdata;
                    if (!e.write) rd_count++;
                end
            end
        end else begin
            check("hsel_idle", HSELx, 1'b0);
            hold_valid = 1'b0;
            if (HREADY) dp_valid = 1'b0;
        end
        ws = HREADY ? 0 : ws + 1;
    endtask

    initial begin
        forever begin
            @(negedge HCLK);
            slave_step();
        end
    end

    task automatic check_reset_outputs();
        check("rst_htrans", HTRANS, 2'd0);
        check("rst_hsel", HSELx, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_hwrite", HWRITE, 1'b0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_hburst", HBURST, 3'd0);
        check("rst_hsize", HSIZE, 3'd2);
        check("rst_hprot", HPROT, 4'd0);
        check("rst_dout", dout, 512'd0);
    endtask

    task automatic run_job(input logic dec, input logic [127:0] k, input logic [511:0] d,
                           input int exp_n, input logic exp_err, input logic poke,
                           output logic [31:0] hw3);
        int  n;
        logic got;
        push_job(dec, k, d);
        rd_count = 0;
        hw3 = '0;
        @(posedge HCLK); #1;
        decrypt = dec; key = k; din = d; start = 1'b1;
        @(posedge HCLK); #1;
        start = 1'b0; key = ~k; din = ~d; decrypt = ~dec;
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(negedge HCLK);
            n++;
            if (n == 1) begin
                check("busy_after_start", busy, 1'b1);
                check("first_haddr", HADDR, dec ? 32'h08 : 32'h04);
                check("first_hburst", HBURST, 3'd0);
            end
            if (n == 2) check("mode_hwdata", HWDATA, 32'h0);
            if (n == 3) begin
                check("key_beat1_haddr", HADDR, 32'h14);
                hw3 = HWDATA;
            end
            if (poke && n == 20) start = 1'b1;
            if (poke && n == 21) start = 1'b0;
            if (done) got = 1'b1;
        end
        check("done_cycle", n, exp_n);
        check("busy_in_done", busy, 1'b1);
        check("error_flag", error, exp_err);
        if (poke) start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        check("done_pulse", done, 1'b0);
        check("busy_clear", busy, 1'b0);
        check("idle_htrans", HTRANS, 2'd0);
    endtask

    initial begin
        logic [127:0] k1, k2;
        logic [511:0] d1, d2, keep;
        logic [31:0]  hw3;
        int           n;

        k1 = "ZXCVBNMASDFGHJKL";
        d1 = {4{"1234567890123456"}};
        HRESET = 1'b1; start = 1'b0; decrypt = 1'b0; key = '0; din = '0;
        HREADY = 1'b1; HRESP = 2'd0; HRDATA = 32'h0;

        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        repeat (5) @(negedge HCLK);
        check_reset_outputs();

        // Zero-wait encrypt job with ignored starts while busy and in DONE.
        run_job(1'b0, k1, d1, 39, 1'b0, 1'b1, hw3);
        check("hwdata_at_0x14", hw3, 32'h5A58_4356);
        check("dout_job1", dout, exp_dout());
        check("sb_empty_job1", sb.size(), 0);

        // Three wait states on the data phase of read 0x88.
        wait_addr = 32'h88; wait_n = 3;
        run_job(1'b0, k1, d1, 42, 1'b0, 1'b0, hw3);
        wait_addr = 32'hFFFF_FFFF;
        check("dout_word2_wait", dout[447:416], model_rd(32'h88));
        check("dout_job2", dout, exp_dout());
        check("sb_empty_job2", sb.size(), 0);

        // ERROR response on write to 0x50 aborts before any read.
        keep = dout;
        err_addr = 32'h50;
        run_job(1'b0, k1, d1, 13, 1'b1, 1'b0, hw3);
        err_addr = 32'hFFFF_FFFF;
        check("err_no_reads", rd_count, 0);
        check("err_dout_kept", dout, keep);
        sb.delete();

        // Decrypt job with random operands.
        k2 = {$urandom, $urandom, $urandom, $urandom};
        d2 = {16{$urandom}};
        for (int i = 0; i < 16; i++) d2[511 - 32*i -: 32] = $urandom;
        run_job(1'b1, k2, d2, 39, 1'b0, 1'b0, hw3);
        check("dec_key_word0", hw3, k2[127:96]);
        check("dout_job4", dout, exp_dout());
        check("sb_empty_job4", sb.size(), 0);

        // Reset during the address phase of write beat 7.
        push_job(1'b0, k1, d1);
        @(posedge HCLK); #1;
        decrypt = 1'b0; key = k1; din = d1; start = 1'b1;
        @(posedge HCLK); #1;
        start = 1'b0;
        n = 0;
        while (n < 12) begin
            @(negedge HCLK);
            n++;
        end
        @(posedge HCLK); #1;
        check("beat7_haddr", HADDR, 32'h5C);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        check_reset_outputs();
        HRESET = 1'b0;
        sb.delete();
        repeat (2) @(negedge HCLK);
        check("post_rst_idle", HTRANS, 2'd0);

        run_job(1'b0, k1, d1, 39, 1'b0, 1'b0, hw3);
        check("dout_after_rst", dout, exp_dout());
        check("sb_empty_after_rst", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_ahb_master.md
# aes_ahb_master

AHB-Lite burst master that drives the AES slave wrapper through one complete job: mode select, 128-bit key load, four 128-bit input blocks, and read-back of four result blocks. It sits directly upstream of the wrapper's slave port and replaces the hand-sequenced bus traffic with a single start/done command interface. It is the only master on its bus segment, so it also drives HSELx.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: offset added to every slave register address.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request; sampled only while busy=0.
- decrypt  in  1  0 = encrypt (mode write to 0x04), 1 = decrypt (0x08); latched on start.
- key  in  128  key; latched on start.
- din  in  512  four input blocks; block 0 = din[511:384]; latched on start.
- busy  out  1  high from the cycle after accepted start through the done cycle.
- done  out  1  one-cycle pulse at job end.
- error  out  1  valid with done; 1 = slave returned ERROR.
- dout  out  512  result blocks; word k read from 0x80+4k lands in dout[511-32k -: 32]; holds until next accepted start.
- HSELx  out  1  high whenever HTRANS is NONSEQ or SEQ.
- HADDR  out  32  address-phase address.
- HTRANS  out  2  IDLE=0, NONSEQ=2, SEQ=3 (BUSY never issued).
- HWRITE  out  1  1 for mode/key/data beats.
- HBURST  out  3  SINGLE=0 for mode beat, INCR=1 otherwise.
- HSIZE  out  3  constant 2 (word).
- HPROT  out  4  constant 0.
- HWDATA  out  32  write data, one cycle after its address phase.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer completion / wait.
- HRESP  in  2  0 = OKAY, 1 = ERROR.

## Operation
- States: IDLE, MODE, KEY, WDATA, RDATA, TAIL, DONE.
- IDLE: all bus outputs idle. start=1 latches decrypt/key/din, clears error and the beat counter, goes to MODE.
- MODE: one NONSEQ/SINGLE write, address 0x04 or 0x08; data phase drives HWDATA=0.
- KEY: NONSEQ 0x10, then SEQ 0x14, 0x18, 0x1C (INCR); data words key[127:96], [95:64], [63:32], [31:0] in that order.
- WDATA: NONSEQ 0x40, SEQ 0x44..0x7C (16 beats); word j = din[511-32j -: 32].
- RDATA: NONSEQ 0x80 with HWRITE=0, SEQ 0x84..0xBC (16 beats).
- TAIL: HTRANS=IDLE, HSELx=0, HADDR=0; completes final read data phase.
- DONE: done=1 for one cycle, then IDLE.
- A 4-bit beat counter indexes key/data words and forms address = base + 4*beat; it wraps only at state change (key uses 0-3, data and read 0-15).
- Bursts are issued back-to-back: the NONSEQ of the next burst overlaps the last data phase of the previous.

## Timing
- Reset: busy, done, error, HSELx, HWRITE = 0; HTRANS = IDLE; HADDR, HWDATA, HBURST, dout = 0; HSIZE = 2; HPROT = 0; state IDLE. Reset mid-job aborts on the same edge; no further beats.
- Zero-wait job: start at edge 0; address phases at cycles 1 (mode), 2-5 (key), 6-21 (write), 22-37 (read); cycle 38 TAIL; done in cycle 39. Latency start to done = 39 cycles + total wait cycles.
- HREADY=0: HADDR, HTRANS, HWRITE, HBURST, HWDATA held unchanged; beat counter frozen. HRDATA captured only on edges with HREADY=1 in a read data phase.
- HRESP=ERROR with HREADY=0 (first error cycle): next cycle drive HTRANS=IDLE, HSELx=0; go to DONE after the second error cycle; done=1, error=1; dout keeps words captured so far.
- start while busy=1 ignored; start in DONE cycle ignored.

## Structure
- Package aes_ahb_pkg: htrans_t and hburst_t enums, HSIZE_WORD, register offset constants (MODE_ENC 0x04, MODE_DEC 0x08, KEY_BASE 0x10, WDATA_BASE 0x40, RDATA_BASE 0x80), state enum.
- Sub-module ahb_pipe_reg: registers the address-phase beat information (write flag, word index) into the data phase, gated by HREADY; the top FSM uses its output to select HWDATA and the dout capture slot.

## Test plan
- Reset then idle 5 cycles -> HTRANS=IDLE, HSELx=0, busy=0, all outputs at reset values.
- start, decrypt=0, key "ZXCVBNMASDFGHJKL", din = 4x "1234567890123456", zero-wait slave model -> addresses 0x04, 0x10-0x1C, 0x40-0x7C, 0x80-0xBC in order; HWDATA at 0x14 phase = 32'h5A584356; done at cycle 39.
- Same job with HREADY=0 for 3 cycles during read of 0x88 -> outputs held stable, done at cycle 42, dout word 2 equals model data.
- Model returns HRESP=ERROR on write to 0x50 -> HTRANS=IDLE cycle after first error cycle, done=1, error=1, no read beats issued.
- decrypt=1 -> first beat address 0x08, HBURST=SINGLE, HWDATA=0.
- HRESET=1 during WDATA beat 7 -> next edge all outputs at reset values; a new start afterwards runs a full clean job.
